// File: rtl/digit_recog_ctrl.sv
// digit_recog_ctrl
//   Frame-level sequencer for the digit recognizer on a raster pixel stream.
//   A start request arms a scan of one full frame to find the bounding box of
//   the dark pixels. An acceptable box is handed to the recognizer for the
//   following frame. A fixed latency after that frame ends, the recognizer
//   result is captured and reported with a one-cycle valid pulse. A missing
//   or undersized box is reported as "no digit".
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   iStart       one-cycle start request, honoured only when idle
//   iValid       pixel qualifier for iRow/iCol/iPixel
//   iRow, iCol   pixel coordinates
//   iPixel       1 = white background, 0 = dark digit pixel
//   iRecDigital  recognizer result
//   oEdge_Row    {bottom, top} of the accepted box
//   oEdge_Col    {right, left} of the accepted box
//   oRecEn       recognizer enable
//   oBusy        high whenever not idle
//   oDigital     last captured digit
//   oNoDigit     last run ended without a usable box
//   oValid       one-cycle pulse when oDigital/oNoDigit are updated
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for iStart
// WAIT_SCAN | started, waiting for start of the scan frame
// SCAN      | tracking the dark-pixel bounding box
// WAIT_REC  | box accepted, waiting for start of the recognition frame
// RECOG     | recognizer enabled for the whole frame
// LATENCY   | recognizer still enabled, counting down to result sampling
// DONE      | result reported (oValid), back to IDLE next cycle

module digit_recog_ctrl #(
   parameter int H_RES    = 640,
   parameter int V_RES    = 480,
   parameter int MIN_SIZE = 8,
   parameter int REC_LAT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iStart,
   input  logic        iValid,
   input  logic [9:0]  iRow,
   input  logic [9:0]  iCol,
   input  logic        iPixel,
   input  logic [3:0]  iRecDigital,
   output logic [19:0] oEdge_Row,
   output logic [19:0] oEdge_Col,
   output logic        oRecEn,
   output logic        oBusy,
   output logic [3:0]  oDigital,
   output logic        oNoDigit,
   output logic        oValid
);

   localparam logic [9:0]  ROW_LAST = 10'(V_RES - 1);
   localparam logic [9:0]  COL_LAST = 10'(H_RES - 1);
   localparam logic [10:0] MIN_SZ   = 11'(MIN_SIZE);
   localparam logic [3:0]  LAT_LOAD = 4'(REC_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SCAN,
      S_SCAN,
      S_WAIT_REC,
      S_RECOG,
      S_LATENCY,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  top_q, top_d, bot_q, bot_d;
   logic [9:0]  left_q, left_d, right_q, right_d;
   logic        found_q, found_d;
   logic [19:0] edge_row_q, edge_row_d, edge_col_q, edge_col_d;
   logic        rec_en_q, rec_en_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  digit_q, digit_d;
   logic        no_digit_q, no_digit_d;

   logic        sof, eof, dark, track, box_ok;
   logic [10:0] height, width;

   always_comb begin
      sof  = iValid && (iRow == 10'd0) && (iCol == 10'd0);
      eof  = iValid && (iRow == ROW_LAST) && (iCol == COL_LAST);
      dark = iValid && !iPixel && (iRow <= ROW_LAST) && (iCol <= COL_LAST);
   end

   // The SOF pixel that moves WAIT_SCAN to SCAN is already part of the scan.
   assign track = (state_q == S_SCAN) || ((state_q == S_WAIT_SCAN) && sof);

   always_comb begin
      top_d   = top_q;
      bot_d   = bot_q;
      left_d  = left_q;
      right_d = right_q;
      found_d = found_q;
      if (track) begin
         if (sof) begin
            top_d   = ROW_LAST;
            bot_d   = '0;
            left_d  = COL_LAST;
            right_d = '0;
            found_d = 1'b0;
         end
         if (dark) begin
            if (iRow < top_d)   top_d   = iRow;
            if (iRow > bot_d)   bot_d   = iRow;
            if (iCol < left_d)  left_d  = iCol;
            if (iCol > right_d) right_d = iCol;
            found_d = 1'b1;
         end
      end
   end

   // Evaluated on the updated box so the EOF pixel itself counts.
   assign height = {1'b0, bot_d} - {1'b0, top_d} + 11'd1;
   assign width  = {1'b0, right_d} - {1'b0, left_d} + 11'd1;
   assign box_ok = found_d && (height >= MIN_SZ) && (width >= MIN_SZ);

   always_comb begin
      state_d    = state_q;
      edge_row_d = edge_row_q;
      edge_col_d = edge_col_q;
      cnt_d      = cnt_q;
      digit_d    = digit_q;
      no_digit_d = no_digit_q;
      case (state_q)
         S_IDLE:      if (iStart) state_d = S_WAIT_SCAN;
         S_WAIT_SCAN: if (sof) state_d = S_SCAN;
         S_SCAN: begin
            if (eof) begin
               if (box_ok) begin
                  edge_row_d = {bot_d, top_d};
                  edge_col_d = {right_d, left_d};
                  state_d    = S_WAIT_REC;
               end else begin
                  no_digit_d = 1'b1;
                  state_d    = S_DONE;
               end
            end
         end
         S_WAIT_REC:  if (sof) state_d = S_RECOG;
         S_RECOG: begin
            if (eof) begin
               cnt_d   = LAT_LOAD;
               state_d = S_LATENCY;
            end
         end
         S_LATENCY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               digit_d    = iRecDigital;
               no_digit_d = 1'b0;
               state_d    = S_DONE;
            end
         end
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   assign rec_en_d = (state_d == S_RECOG) || (state_d == S_LATENCY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         top_q      <= ROW_LAST;
         bot_q      <= '0;
         left_q     <= COL_LAST;
         right_q    <= '0;
         found_q    <= 1'b0;
         edge_row_q <= '0;
         edge_col_q <= '0;
         rec_en_q   <= 1'b0;
         cnt_q      <= '0;
         digit_q    <= '0;
         no_digit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         top_q      <= top_d;
         bot_q      <= bot_d;
         left_q     <= left_d;
         right_q    <= right_d;
         found_q    <= found_d;
         edge_row_q <= edge_row_d;
         edge_col_q <= edge_col_d;
         rec_en_q   <= rec_en_d;
         cnt_q      <= cnt_d;
         digit_q    <= digit_d;
         no_digit_q <= no_digit_d;
      end
   end

   // Enable must already be high on the SOF pixel of the recognition frame.
   assign oRecEn    = rec_en_q || ((state_q == S_WAIT_REC) && sof);
   assign oBusy     = (state_q != S_IDLE);
   assign oValid    = (state_q == S_DONE);
   assign oEdge_Row = edge_row_q;
   assign oEdge_Col = edge_col_q;
   assign oDigital  = digit_q;
   assign oNoDigit  = no_digit_q;

endmodule
